subtractor_4bit: RTL and testbench

- Registered 4-bit unsigned/two's-complement subtractor: S = A - B, computed as A + ~B + 1 through a 4-stage ripple full-adder chain.
- Operand and result bits are carried on individual scalar ports, LSB = index 0.
- final_carry is the carry out of the MSB stage: 1 = no borrow (A >= B unsigned), 0 = borrow.
- Small datapath leaf used wherever a registered 4-bit difference and borrow status are needed.

---
 rtl/subtractor_4bit.sv | 84 ++++++++
 tb/tb_subtractor_4bit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/subtractor_4bit.sv
// Registered 4-bit subtractor S = A - B built as A + ~B + 1 over a ripple full-adder chain.
// Optional macro SUBTRACTOR_4BIT_OVERFLOW_EN adds a registered signed-overflow output.
module subtractor_4bit (
    input  logic clk,
    input  logic rst,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
`ifdef SUBTRACTOR_4BIT_OVERFLOW_EN
    output logic overflow,
`endif
    output logic final_carry
);

    localparam int unsigned W = 4;

    logic [W-1:0] a_vec;
    logic [W-1:0] b_inv;
    logic [W-1:0] diff_next;
    logic         c1;
    logic         c2;
    logic         c3;
    logic         c4;

    logic [W-1:0] diff_q;
    logic         carry_q;

    assign a_vec = {a3, a2, a1, a0};
    assign b_inv = ~{b3, b2, b1, b0};

    // Ripple chain; carry-in of stage 0 is tied high to complete the two's complement of B
    always_comb begin
        diff_next[0] = a_vec[0] ^ b_inv[0] ^ 1'b1;
        c1           = a_vec[0] | b_inv[0];
        diff_next[1] = a_vec[1] ^ b_inv[1] ^ c1;
        c2           = (a_vec[1] & b_inv[1]) | (a_vec[1] & c1) | (b_inv[1] & c1);
        diff_next[2] = a_vec[2] ^ b_inv[2] ^ c2;
        c3           = (a_vec[2] & b_inv[2]) | (a_vec[2] & c2) | (b_inv[2] & c2);
        diff_next[3] = a_vec[3] ^ b_inv[3] ^ c3;
        c4           = (a_vec[3] & b_inv[3]) | (a_vec[3] & c3) | (b_inv[3] & c3);
    end

    // Output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            diff_q  <= diff_next;
            carry_q <= c4;
        end
    end

`ifdef SUBTRACTOR_4BIT_OVERFLOW_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= c3 ^ c4;
        end
    end

    assign overflow = ovf_q;
`endif

    assign s0          = diff_q[0];
    assign s1          = diff_q[1];
    assign s2          = diff_q[2];
    assign s3          = diff_q[3];
    assign final_carry = carry_q;

endmodule

// File: tb/tb_subtractor_4bit.sv
// Self-checking bench for subtractor_4bit: reset, latency, directed table and exhaustive sweep.
module tb_subtractor_4bit;

    logic clk;
    logic rst;
    logic a0, a1, a2, a3;
    logic b0, b1, b2, b3;
    logic s0, s1, s2, s3;
    logic final_carry;
`ifdef SUBTRACTOR_4BIT_OVERFLOW_EN
    logic overflow;
`endif

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       c;
        logic       ov;
    } vec_t;

    subtractor_4bit dut (
        .clk         (clk),
        .rst         (rst),
        .a0          (a0),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .b3          (b3),
        .s0          (s0),
        .s1          (s1),
        .s2          (s2),
        .s3          (s3),
`ifdef SUBTRACTOR_4BIT_OVERFLOW_EN
        .overflow    (overflow),
`endif
        .final_carry (final_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] a, input logic [3:0] b);
        {a3, a2, a1, a0} = a;
        {b3, b2, b1, b0} = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] s_exp, input logic c_exp,
                         input logic ov_exp);
        logic [3:0] s_act;
        s_act = {s3, s2, s1, s0};
        tests_run++;
        if (s_act !== s_exp || final_carry !== c_exp) begin
            tests_failed++;
            $display("FAIL %s: got s=%b carry=%b, expected s=%b carry=%b",
                     name, s_act, final_carry, s_exp, c_exp);
        end
`ifdef SUBTRACTOR_4BIT_OVERFLOW_EN
        tests_run++;
        if (overflow !== ov_exp) begin
            tests_failed++;
            $display("FAIL %s overflow: got %b, expected %b", name, overflow, ov_exp);
        end
`else
        if (ov_exp === 1'bx) $display("unused");
`endif
    endtask

    initial begin
        vec_t vecs[$];
        tests_run    = 0;
        tests_failed = 0;

        vecs.push_back('{4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0}); // 10 - 10
        vecs.push_back('{4'b0011, 4'b0110, 4'b1101, 1'b0, 1'b0}); // 3 - 6
        vecs.push_back('{4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0}); // 0 - 1 wraps
        vecs.push_back('{4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0}); // 15 - 0
        vecs.push_back('{4'b0000, 4'b1111, 4'b0001, 1'b0, 1'b0}); // 0 - 15
        vecs.push_back('{4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0}); // 8 - 8
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0}); // 0 - 0
        vecs.push_back('{4'b0111, 4'b1000, 4'b1111, 1'b0, 1'b1}); // 7 - (-8)
        vecs.push_back('{4'b0110, 4'b0011, 4'b0011, 1'b1, 1'b0}); // 6 - 3
        vecs.push_back('{4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1}); // -8 - 1
        vecs.push_back('{4'b1010, 4'b0011, 4'b0111, 1'b1, 1'b1}); // -6 - 3

        // Reset held while clocking with live operands
        rst = 1'b1;
        drive(4'b1010, 4'b0011);
        #2;
        check("reset_initial", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", 4'b0000, 1'b0, 1'b0);
        end

        @(negedge clk);
        rst = 1'b0;
        drive(4'b1010, 4'b1010);
        step();
        check("eq_10_10", 4'b0000, 1'b1, 1'b0);

        // Latency: new operands must not show before the next edge
        drive(4'b0110, 4'b0011);
        #3;
        check("latency_before_edge", 4'b0000, 1'b1, 1'b0);
        step();
        check("latency_after_edge", 4'b0011, 1'b1, 1'b0);

        // Back-to-back directed table, one new operand pair per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].b);
            step();
            check($sformatf("vec%0d_%0d_minus_%0d", i, vecs[i].a, vecs[i].b),
                  vecs[i].s, vecs[i].c, vecs[i].ov);
        end

        // Exhaustive sweep against an arithmetic reference
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                int         sd;
                logic [3:0] s_exp;
                logic       c_exp;
                logic       ov_exp;
                s_exp  = 4'((x - y + 16) % 16);
                c_exp  = (x >= y);
                sd     = (x > 7 ? x - 16 : x) - (y > 7 ? y - 16 : y);
                ov_exp = (sd > 7) || (sd < -8);
                drive(4'(x), 4'(y));
                step();
                check($sformatf("sweep_%0d_minus_%0d", x, y), s_exp, c_exp, ov_exp);
            end
        end

        // Asynchronous reset mid-cycle discards the result without a clock edge
        drive(4'b1111, 4'b0000);
        step();
        check("pre_async_reset", 4'b1111, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_cycle", 4'b0000, 1'b0, 1'b0);
        step();
        check("async_reset_held", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 4'b1111);
        step();
        check("after_reset_release", 4'b0001, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
